kd_node_config_streamer: RTL and testbench
==========================================

Name: kd_node_config_streamer

Overview:
- Transmit end of the internal-node configuration interface of the KD-tree.
- Accepts per-node records (split dimension index, median) from an upstream valid/ready source, then packs and streams them as write words on the tree's sender_enable/sender_data write port.
- Keeps the tree's free-running write address aligned: after the real records, it sends pad words until the 2**ADDR_BITS address space wraps back to 0.
- Sits between the configuration loader/host FSM and the internal node tree.

Parameters:
- NUM_NODES, 63, number of real internal-node records per load (tree of depth 6).
- ADDR_BITS, 6, width of the tree's write address; one load always emits exactly 2**ADDR_BITS words.
- IDX_WIDTH, 3, width of the split-dimension index field.
- MEDIAN_WIDTH, 11, signed median width.
- NUM_DIMS, 5, number of legal dimensions; legal idx range is 0..NUM_DIMS-1.
- WORD_WIDTH, 22, packed output word width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- start  in  1  one-cycle pulse; begins a load.
- in_valid  in  1  upstream record valid.
- in_ready  out  1  streamer can accept a record this cycle.
- in_idx  in  IDX_WIDTH  split dimension of the record.
- in_median  in  MEDIAN_WIDTH  signed median of the record.
- fsm_enable  out  1  write window open to the tree.
- sender_enable  out  1  write strobe; sender_data valid.
- sender_data  out  WORD_WIDTH  packed word.
- busy  out  1  load in progress.
- done  out  1  load complete; sticky until next start.
- idx_err  out  1  sticky flag: at least one record had idx >= NUM_DIMS.
- words_sent  out  ADDR_BITS+1  count of words emitted in the current load.

Behaviour:
- Clock and reset: clk; reset rst_n, synchronous, active-low. Reset wins over every other input.
- Reset values:
  - state=IDLE; rec_cnt=0; words_sent=0.
  - in_ready=0, sender_enable=0, sender_data=0, fsm_enable=0, busy=0, done=0, idx_err=0.
- Packing:
  - sender_data[2:0]=idx.
  - sender_data[10:3]=0.
  - sender_data[21:11]=median (bit-exact, two's complement).
- States:
  - IDLE: start -> LOAD. On entry to LOAD, clear rec_cnt, words_sent, done and idx_err.
  - LOAD:
    - in_ready = (rec_cnt < NUM_NODES). An accept is in_valid && in_ready.
    - Each accept: rec_cnt++; if in_idx >= NUM_DIMS, set idx_err (the record is still forwarded unchanged).
    - When the accept makes rec_cnt == NUM_NODES, next state is PAD if NUM_NODES < 2**ADDR_BITS, else DONE.
    - in_valid low stalls indefinitely with no output.
  - PAD:
    - in_ready=0.
    - Emit one pad word per cycle: idx=3'b111, median=0, i.e. sender_data=22'h000007.
    - Emit 2**ADDR_BITS - NUM_NODES words, then go to DONE.
  - DONE: done=1. start -> LOAD (new load). Otherwise hold.
- start is ignored in LOAD and PAD.
- Output registers, latency 1:
  - An accept in cycle N produces sender_enable=1 and sender_data=packed record in cycle N+1.
  - A pad word is registered the same way.
  - sender_enable is never high without a preceding accept or pad cycle.
- Throughput: one word per cycle. Back-to-back accepts give back-to-back strobes.
- fsm_enable = 1 in LOAD and PAD, and in the cycle of the final sender_enable. It is 0 otherwise, so fsm_enable && sender_enable is exactly the write strobe.
- words_sent increments on every cycle with sender_enable=1, and equals 2**ADDR_BITS when done rises.
- done and the last sender_enable: done rises in the cycle after the last sender_enable.
- busy = state is LOAD or PAD, or sender_enable=1.
- Reset mid-load: everything returns to reset values next cycle and no further strobes are issued. The tree must be reset concurrently, because the streamer does not resynchronise the tree address.

Test Plan:
- Reset, then start, then 63 records on consecutive cycles with idx=i%5 and median=i-31 -> 63 strobes on cycles 2..64. Word 0=22'h3F0800 (idx0, median -31), word 62=22'h00F802 (idx2, median 31). Word 63=22'h000007. done=1 on cycle 66, idx_err=0, words_sent=64.
- Same load with in_valid toggling 1,0,1,0 -> strobes only one cycle after each accept; total 64 strobes; no strobe while stalled; in_ready=0 after record 63.
- Record 10 carries idx=6 -> idx_err=1 sticky, word 10 has [2:0]=6, load still completes. A new start clears idx_err.
- start pulsed again mid-LOAD after record 20 -> ignored; exactly 64 words in total.
- rst_n low after record 30 -> all outputs 0 next cycle, no strobe afterwards. A new start and 63 records complete normally with words_sent=64.
- NUM_NODES=64 -> no PAD state; done follows the 64th strobe; no 22'h000007 word emitted.

Source files
------------

// File: rtl/kd_node_config_streamer.sv
// Streams KD-tree internal-node records as packed write words, padding the load out to a
// full 2**ADDR_BITS words so the tree's free-running write address wraps back to 0.
module kd_node_config_streamer #(
    parameter int unsigned NUM_NODES    = 63,
    parameter int unsigned ADDR_BITS    = 6,
    parameter int unsigned IDX_WIDTH    = 3,
    parameter int unsigned MEDIAN_WIDTH = 11,
    parameter int unsigned NUM_DIMS     = 5,
    parameter int unsigned WORD_WIDTH   = 22
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IDX_WIDTH-1:0]    in_idx,
    input  logic [MEDIAN_WIDTH-1:0] in_median,
    output logic                    fsm_enable,
    output logic                    sender_enable,
    output logic [WORD_WIDTH-1:0]   sender_data,
    output logic                    busy,
    output logic                    done,
    output logic                    idx_err,
    output logic [ADDR_BITS:0]      words_sent
);

    localparam int unsigned TOTAL = 1 << ADDR_BITS;
    localparam int unsigned CW    = ADDR_BITS + 1;
    localparam int unsigned GAP   = WORD_WIDTH - IDX_WIDTH - MEDIAN_WIDTH;

    localparam logic [CW-1:0] NODES_C = CW'(NUM_NODES);
    localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
    localparam logic [WORD_WIDTH-1:0] PAD_WORD = WORD_WIDTH'({IDX_WIDTH{1'b1}});

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]            state_q, state_d;
    // Index of the next word to issue: records first, then pad words.
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         words_q, words_d;
    logic                  se_q, se_d;
    logic [WORD_WIDTH-1:0] data_q, data_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  accept;
    logic                  idx_bad;

    assign in_ready = (state_q == LOAD) && (cnt_q < NODES_C);
    assign accept   = in_valid && in_ready;
    assign idx_bad  = ({{(32 - IDX_WIDTH){1'b0}}, in_idx} >= NUM_DIMS);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        words_d = words_q + CW'(se_q);
        se_d    = 1'b0;
        data_d  = '0;
        done_d  = done_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    words_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                if (accept) begin
                    se_d   = 1'b1;
                    data_d = {in_median, {GAP{1'b0}}, in_idx};
                    cnt_d  = cnt_q + CW'(1);
                    if (idx_bad) err_d = 1'b1;
                    if (cnt_d == NODES_C) state_d = (NUM_NODES < TOTAL) ? PAD : DONE;
                end
            end
            PAD: begin
                se_d   = 1'b1;
                data_d = PAD_WORD;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST_C) state_d = DONE;
            end
            DONE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                    words_d = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end else if (se_q) begin
                    // The final word is on the bus this cycle; done follows it.
                    done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            words_q <= '0;
            se_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            words_q <= words_d;
            se_q    <= se_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign fsm_enable    = (state_q == LOAD) || (state_q == PAD) || se_q;
    assign busy          = (state_q == LOAD) || (state_q == PAD) || se_q;
    assign sender_enable = se_q;
    assign sender_data   = data_q;
    assign done          = done_q;
    assign idx_err       = err_q;
    assign words_sent    = words_q;

endmodule

// File: tb/tb_kd_node_config_streamer.sv
// Bench for kd_node_config_streamer: a 63-node and a 64-node instance share one stimulus
// stream and are each checked every cycle against a record/pad bookkeeping model.
module tb_kd_node_config_streamer;

    localparam int TOTAL = 64;
    localparam int DIMS  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [2:0]  in_idx = '0;
    logic [10:0] in_median = '0;

    logic [1:0]        in_ready, fsm_enable, sender_enable, busy, done, idx_err;
    logic [1:0][21:0]  sender_data;
    logic [1:0][6:0]   words_sent;

    always #5 clk = ~clk;

    kd_node_config_streamer #(.NUM_NODES(63)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready[0]), .in_idx(in_idx), .in_median(in_median),
        .fsm_enable(fsm_enable[0]), .sender_enable(sender_enable[0]),
        .sender_data(sender_data[0]), .busy(busy[0]), .done(done[0]),
        .idx_err(idx_err[0]), .words_sent(words_sent[0])
    );

    kd_node_config_streamer #(.NUM_NODES(64)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready[1]), .in_idx(in_idx), .in_median(in_median),
        .fsm_enable(fsm_enable[1]), .sender_enable(sender_enable[1]),
        .sender_data(sender_data[1]), .busy(busy[1]), .done(done[1]),
        .idx_err(idx_err[1]), .words_sent(words_sent[1])
    );

    // Reference model state, one entry per instance.
    int          nn[2];
    bit          act[2];
    int          recs[2];
    int          pads_left[2];
    int          words[2];
    bit          fin[2];
    bit          err[2];
    bit          exp_se[2];
    bit          final_now[2];
    logic [21:0] exp_data[2];
    logic [21:0] seen0[$];
    logic [21:0] seen1[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
        end
    endtask

    function automatic logic [21:0] pack(input int idx, input int med);
        return 22'((med & 'h7FF) * 2048 + idx);
    endfunction

    task automatic tick();
        bit          s_se[2];
        logic [21:0] s_data[2];
        bit          s_fin[2];
        for (int d = 0; d < 2; d++) begin
            s_se[d] = 1'b0; s_data[d] = '0; s_fin[d] = 1'b0;
            if (!rst_n) begin
                act[d] = 0; recs[d] = 0; pads_left[d] = 0; words[d] = 0;
                fin[d] = 0; err[d] = 0;
            end else begin
                if (exp_se[d]) words[d]++;
                if (final_now[d]) fin[d] = 1;
                if (act[d] && recs[d] < nn[d]) begin
                    if (in_valid) begin
                        s_se[d] = 1; s_data[d] = pack(int'(in_idx), int'(in_median));
                        recs[d]++;
                        if (int'(in_idx) >= DIMS) err[d] = 1;
                        if (recs[d] == nn[d]) begin
                            pads_left[d] = TOTAL - nn[d];
                            if (pads_left[d] == 0) begin act[d] = 0; s_fin[d] = 1; end
                        end
                    end
                end else if (act[d]) begin
                    s_se[d] = 1; s_data[d] = 22'h000007;
                    pads_left[d]--;
                    if (pads_left[d] == 0) begin act[d] = 0; s_fin[d] = 1; end
                end else if (start) begin
                    act[d] = 1; recs[d] = 0; words[d] = 0; fin[d] = 0; err[d] = 0;
                    if (d == 0) seen0.delete(); else seen1.delete();
                end
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            exp_se[d] = s_se[d]; exp_data[d] = s_data[d]; final_now[d] = s_fin[d];
            if (sender_enable[d]) begin
                if (d == 0) seen0.push_back(sender_data[d]); else seen1.push_back(sender_data[d]);
            end
            chk("in_ready", d, 32'(in_ready[d]), 32'(act[d] && recs[d] < nn[d]));
            chk("sender_enable", d, 32'(sender_enable[d]), 32'(exp_se[d]));
            chk("sender_data", d, 32'(sender_data[d]), 32'(exp_data[d]));
            chk("fsm_enable", d, 32'(fsm_enable[d]), 32'(act[d] || exp_se[d]));
            chk("busy", d, 32'(busy[d]), 32'(act[d] || exp_se[d]));
            chk("done", d, 32'(done[d]), 32'(fin[d]));
            chk("idx_err", d, 32'(idx_err[d]), 32'(err[d]));
            chk("words_sent", d, 32'(words_sent[d]), 32'(words[d]));
        end
    endtask

    // mode 0: continuous, 1: alternate valid, 2: random valid/idx/median.
    task automatic feed(input int mode, input int bad_at, input int restart_at, input int rst_at);
        int i = 0;
        int cyc = 0;
        bit v;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (i < TOTAL && cyc < 600) begin
            v = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
            in_valid  = v;
            in_idx    = (i == bad_at) ? 3'd6 : (mode == 2) ? 3'($urandom % 8) : 3'(i % 5);
            in_median = (mode == 2) ? 11'($urandom) : 11'(i - 31);
            start     = (i == restart_at);
            if (i == rst_at) begin
                rst_n = 1'b0; in_valid = 1'b0; start = 1'b0;
                tick();
                rst_n = 1'b1;
                repeat (4) tick();
                return;
            end
            tick();
            if (v) i++;
            cyc++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done[0] && done[1]) break;
            tick();
        end
        tick();
        chk("load_done", 0, 32'(done[0]), 32'd1);
        chk("load_done", 1, 32'(done[1]), 32'd1);
        chk("final_words", 0, 32'(words_sent[0]), 32'd64);
        chk("final_words", 1, 32'(words_sent[1]), 32'd64);
    endtask

    initial begin
        int pads1;
        nn[0] = 63; nn[1] = 64;
        for (int d = 0; d < 2; d++) begin
            act[d] = 0; recs[d] = 0; pads_left[d] = 0; words[d] = 0;
            fin[d] = 0; err[d] = 0; exp_se[d] = 0; final_now[d] = 0; exp_data[d] = '0;
        end

        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Directed full-rate load with the reference record pattern.
        feed(0, -1, -1, -1);
        chk("seen_count", 0, 32'(seen0.size()), 32'd64);
        chk("seen_count", 1, 32'(seen1.size()), 32'd64);
        if (seen0.size() == 64) begin
            chk("word0", 0, 32'(seen0[0]), 32'h3F0800);
            chk("word62", 0, 32'(seen0[62]), 32'h00F802);
            chk("word63_pad", 0, 32'(seen0[63]), 32'h000007);
        end
        if (seen1.size() == 64) chk("word63_rec", 1, 32'(seen1[63]), 32'h010003);
        pads1 = 0;
        foreach (seen1[k]) if (seen1[k] == 22'h000007) pads1++;
        chk("no_pad_n64", 1, 32'(pads1), 32'd0);

        // Alternating valid, then a bad idx on record 10, then a restart clearing idx_err.
        feed(1, -1, -1, -1);
        feed(0, 10, -1, -1);
        if (seen0.size() > 10) chk("bad_idx_word", 0, 32'(seen0[10][2:0]), 32'd6);
        feed(0, -1, -1, -1);

        // start pulsed mid-load must be ignored.
        feed(1, -1, 20, -1);

        // Reset mid-load, then a clean load.
        feed(0, -1, -1, 30);
        feed(0, -1, -1, -1);

        // Randomized loads.
        repeat (3) feed(2, -1, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
